// File: rtl/iter_alu.sv
// -----------------------------------------------------------------------------
// iter_alu -- registered execute-stage ALU with iterative multiply/divide.
//
// Single-cycle ops (and, or, add, sub, slt) are written to ALUout at the edge
// that accepts start; done pulses in the following cycle. mul, divu and remu
// run one bit per clock (shift-add multiply, restoring divide) behind a
// start/busy/done handshake. The controller stalls while busy is high.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       operation request, sampled only while busy is low
//   srcA, srcB  operands (WIDTH bits), free to change after acceptance
//   aluControl  3-bit operation select
//   ALUout      registered result, held until the next completion
//   zeroFlag    registered, high when ALUout is zero
//   busy        iterative operation in progress
//   done        one-cycle pulse whenever ALUout/zeroFlag update
// -----------------------------------------------------------------------------
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       aluControl,
    output logic [WIDTH-1:0] ALUout,
    output logic             zeroFlag,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       op_r;
    // acc_r: product accumulator (mul) or partial remainder (div/rem)
    // opa_r: multiplier shifted right (mul) or dividend->quotient (div/rem)
    // opb_r: multiplicand shifted left (mul) or divisor (div/rem)
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;

    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] opa_nxt_s;
    logic [WIDTH-1:0] opb_nxt_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] single_res_s;
    logic [WIDTH-1:0] final_res_s;
    logic             is_iter_s;

    function automatic logic [WIDTH-1:0] single_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign single_res_s = single_op(aluControl, srcA, srcB);
    assign is_iter_s    = (aluControl == OP_MUL) || (aluControl == OP_DIVU) ||
                          (aluControl == OP_REMU);

    // One iteration step for the shift-add multiplier or the restoring divider
    always_comb begin
        acc_nxt_s = acc_r;
        opa_nxt_s = opa_r;
        opb_nxt_s = opb_r;
        // Shift the next dividend bit into the remainder and trial-subtract;
        // the extra top bit is the borrow (negative result -> restore).
        trial_s   = {acc_r, opa_r[WIDTH-1]} - {1'b0, opb_r};
        if (op_r == OP_MUL) begin
            if (opa_r[0]) begin
                acc_nxt_s = acc_r + opb_r;
            end else begin
                acc_nxt_s = acc_r;
            end
            opa_nxt_s = {1'b0, opa_r[WIDTH-1:1]};
            opb_nxt_s = {opb_r[WIDTH-2:0], 1'b0};
        end else begin
            if (!trial_s[WIDTH]) begin
                acc_nxt_s = trial_s[WIDTH-1:0];
                opa_nxt_s = {opa_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {acc_r[WIDTH-2:0], opa_r[WIDTH-1]};
                opa_nxt_s = {opa_r[WIDTH-2:0], 1'b0};
            end
            opb_nxt_s = opb_r;
        end
    end

    // Pick the finished iterative result for the latched opcode
    always_comb begin
        case (op_r)
            OP_MUL:  final_res_s = acc_r;
            OP_DIVU: final_res_s = opa_r;
            OP_REMU: final_res_s = acc_r;
            default: final_res_s = acc_r;
        endcase
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 3'b000;
            acc_r    <= {WIDTH{1'b0}};
            opa_r    <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            ALUout   <= {WIDTH{1'b0}};
            zeroFlag <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (is_iter_s) begin
                            op_r    <= aluControl;
                            opa_r   <= srcA;
                            opb_r   <= srcB;
                            acc_r   <= {WIDTH{1'b0}};
                            cnt_r   <= CNT_INIT;
                            busy    <= 1'b1;
                            state_r <= RUN;
                        end else begin
                            ALUout   <= single_res_s;
                            zeroFlag <= (single_res_s == {WIDTH{1'b0}});
                            done     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_r <= acc_nxt_s;
                    opa_r <= opa_nxt_s;
                    opb_r <= opb_nxt_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= FINISH;
                    end
                end
                FINISH: begin
                    ALUout   <= final_res_s;
                    zeroFlag <= (final_res_s == {WIDTH{1'b0}});
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
